// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised oversampling UART receiver with parity, stop and break detection
module uart_rx_param #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_RX,
  input  logic                  RST_RX,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [3:0]            data_len,
  input  logic [5:0]            prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  break_det,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [3:0] DW4 = 4'(DATA_WIDTH);

  state_t                state, state_nxt;
  logic [5:0]            p_lat;
  logic [5:0]            edge_cnt;
  logic [3:0]            len_lat;
  logic [3:0]            bit_cnt;
  logic                  par_en_lat;
  logic                  par_typ_lat;
  logic                  stop2_lat;
  logic [DATA_WIDTH-1:0] shreg;
  logic [2:0]            samp;
  logic                  par_flag;
  logic                  stop_flag;
  logic                  brk_flag;
  logic                  zero_all;

  logic [5:0]            p_dec;
  logic [5:0]            half;
  logic [3:0]            len_dec;
  logic                  bit_end;
  logic                  bit_val;
  logic                  last_data;
  logic                  last_stop;
  logic                  start_entry;
  logic                  in_bit;

  // Unsupported prescale falls back to 8; out-of-range length falls back to the full width.
  assign p_dec       = (prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd8;
  assign len_dec     = (data_len >= 4'd5 && data_len <= DW4) ? data_len : DW4;
  assign half        = p_lat >> 1;
  assign bit_end     = (edge_cnt == p_lat - 6'd1);
  assign bit_val     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign last_data   = (bit_cnt == len_lat - 4'd1);
  assign last_stop   = !stop2_lat || (bit_cnt == 4'd1);
  assign start_entry = (state == IDLE || state == DONE) && !RX_IN;
  assign in_bit      = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; every bit state moves on only at the last oversample tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!RX_IN) state_nxt = START;
      START:   if (bit_end) state_nxt = bit_val ? IDLE : DATA;
      DATA:    if (bit_end && last_data) state_nxt = par_en_lat ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = DONE;
      DONE:    state_nxt = RX_IN ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: oversample counters, majority sampling, capture, error flags and registered outputs.
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) begin
      p_lat        <= 6'd8;
      edge_cnt     <= '0;
      len_lat      <= DW4;
      bit_cnt      <= '0;
      par_en_lat   <= 1'b0;
      par_typ_lat  <= 1'b0;
      stop2_lat    <= 1'b0;
      shreg        <= '0;
      samp         <= '0;
      par_flag     <= 1'b0;
      stop_flag    <= 1'b0;
      brk_flag     <= 1'b0;
      zero_all     <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      break_det    <= 1'b0;

      if (in_bit) begin
        if (edge_cnt == half - 6'd1) samp[0] <= RX_IN;
        if (edge_cnt == half)        samp[1] <= RX_IN;
        if (edge_cnt == half + 6'd1) samp[2] <= RX_IN;
        if (bit_end) edge_cnt <= '0;
        else         edge_cnt <= edge_cnt + 6'd1;
      end

      if (bit_end) begin
        case (state)
          DATA: begin
            shreg <= shreg | (DATA_WIDTH'(bit_val) << bit_cnt);
            if (bit_val) zero_all <= 1'b0;
            bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
          end
          PARITY: begin
            if (bit_val != ((^shreg) ^ par_typ_lat)) par_flag <= 1'b1;
            if (bit_val) zero_all <= 1'b0;
          end
          STOP: begin
            if (!bit_val) stop_flag <= 1'b1;
            if (bit_cnt == 4'd0 && zero_all && !bit_val) brk_flag <= 1'b1;
            bit_cnt <= bit_cnt + 4'd1;
          end
          default: bit_cnt <= '0;
        endcase
      end

      if (state == DONE) begin
        if (!par_flag && !stop_flag) begin
          P_DATA     <= shreg;
          data_valid <= 1'b1;
        end else begin
          parity_error <= par_flag;
          stop_error   <= stop_flag;
          break_det    <= brk_flag;
        end
      end

      // A start seen from DONE is already one cycle into the start bit, so the
      // counter begins at 1 to keep back-to-back frames from drifting.
      if (start_entry) begin
        p_lat       <= p_dec;
        len_lat     <= len_dec;
        par_en_lat  <= PAR_EN;
        par_typ_lat <= PAR_TYP;
        stop2_lat   <= STOP2;
        edge_cnt    <= (state == DONE) ? 6'd1 : 6'd0;
        bit_cnt     <= '0;
        shreg       <= '0;
        par_flag    <= 1'b0;
        stop_flag   <= 1'b0;
        brk_flag    <= 1'b0;
        zero_all    <= 1'b1;
      end
    end
  end

endmodule
